// File: rtl/seq_shift_add_mul.sv
// Sequential radix-2 shift-add multiplier: one partial product per clock, start/busy/done handshake.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands (final partial product subtracted).
module seq_shift_add_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q,   state_d;
    logic [PW-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q,     acc_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
    logic [PW-1:0]   acc_next;
    logic            last_iter;

    // Multiplicand is widened once at capture so every shift stays within the accumulator width.
    function automatic logic [PW-1:0] extend_mcand(input logic [WIDTH-1:0] v);
`ifdef SEQ_MUL_SIGNED_EN
        return {{WIDTH{v[WIDTH-1]}}, v};
`else
        return {{WIDTH{1'b0}}, v};
`endif
    endfunction

    function automatic logic [PW-1:0] accum_step(
        input logic [PW-1:0]    acc,
        input logic [PW-1:0]    mcand,
        input logic [WIDTH-1:0] mplier,
        input logic [CW-1:0]    cnt
    );
        logic [PW-1:0] pp;
        pp = mcand << cnt;
        if (!mplier[cnt]) return acc;
`ifdef SEQ_MUL_SIGNED_EN
        // The multiplier's sign bit carries weight -2^(W-1).
        if (cnt == CW'(WIDTH - 1)) return acc - pp;
`endif
        return acc + pp;
    endfunction

    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign acc_next  = accum_step(acc_q, mcand_q, mplier_q, cnt_q);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d  = extend_mcand(a);
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    product_d = acc_next;
                    cnt_d     = '0;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Scoreboard bench for seq_shift_add_mul at WIDTH=4 and WIDTH=8; honours SEQ_MUL_SIGNED_EN.
module tb_seq_shift_add_mul;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, start8;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  product4;
    logic [15:0] product8;

    logic [63:0] q4[$];
    logic [63:0] q8[$];
    logic [63:0] cur4 = 0, prev4 = 0, cur8 = 0, prev8 = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    seq_shift_add_mul #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(product4)
    );

    seq_shift_add_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(product8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference product of w-bit operands, truncated to 2*w bits.
    function automatic logic [63:0] mul_ref(input int w, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, p;
        sx = {32'b0, x};
        sy = {32'b0, y};
`ifdef SEQ_MUL_SIGNED_EN
        if (x[w-1]) sx = sx - (64'sd1 <<< w);
        if (y[w-1]) sy = sy - (64'sd1 <<< w);
`endif
        p = sx * sy;
        return p & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (q4.size() == 0) chk("spurious_done4", 1, 0);
            else chk("product4", {56'b0, product4}, q4.pop_front());
        end
        if (rst_n && done8) begin
            if (q8.size() == 0) chk("spurious_done8", 1, 0);
            else chk("product8", {48'b0, product8}, q8.pop_front());
        end
    end

    task automatic go4(input logic [3:0] x, input logic [3:0] y);
        start4 = 1'b1; a4 = x; b4 = y;
        prev4 = cur4;
        cur4  = mul_ref(4, {28'b0, x}, {28'b0, y});
        q4.push_back(cur4);
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    endtask

    task automatic go8(input logic [7:0] x, input logic [7:0] y);
        start8 = 1'b1; a8 = x; b8 = y;
        prev8 = cur8;
        cur8  = mul_ref(8, {24'b0, x}, {24'b0, y});
        q8.push_back(cur8);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    // Waits for done, checking busy and a held product each RUN cycle; inj drives a stray start.
    task automatic wait4(input int inj);
        int n;
        n = 0;
        @(negedge clk);
        while (!done4 && n < 40) begin
            chk("busy4", {63'b0, busy4}, 1);
            chk("hold4", {56'b0, product4}, prev4);
            if (n == inj) begin start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; end
            else start4 = 1'b0;
            n++;
            @(negedge clk);
        end
        start4 = 1'b0;
        chk("latency4", n, 4);
        chk("busy_at_done4", {63'b0, busy4}, 0);
    endtask

    task automatic wait8();
        int n;
        n = 0;
        @(negedge clk);
        while (!done8 && n < 60) begin
            if (busy8 !== 1'b1) chk("busy8", {63'b0, busy8}, 1);
            if (product8 !== prev8[15:0]) chk("hold8", {48'b0, product8}, prev8);
            n++;
            @(negedge clk);
        end
        chk("latency8", n, 8);
    endtask

    task automatic idle4();
        @(negedge clk);
        chk("done_fall4", {63'b0, done4}, 0);
        chk("idle_busy4", {63'b0, busy4}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy4", {63'b0, busy4}, 0);
        chk("rst_done4", {63'b0, done4}, 0);
        chk("rst_prod4", {56'b0, product4}, 0);
        chk("rst_busy8", {63'b0, busy8}, 0);
        chk("rst_done8", {63'b0, done8}, 0);
        chk("rst_prod8", {48'b0, product8}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        go4(4'hF, 4'hF); wait4(-1); idle4();

        go4(4'h0, 4'hB); wait4(-1);
        go4(4'h7, 4'h3); wait4(-1); idle4();

        go4(4'h5, 4'h6); wait4(1); idle4();

        // Asynchronous reset in the middle of RUN discards the operation.
        go4(4'h9, 4'h9);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy4", {63'b0, busy4}, 0);
        chk("arst_done4", {63'b0, done4}, 0);
        chk("arst_prod4", {56'b0, product4}, 0);
        q4.delete();
        cur4 = 0; prev4 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("no_done_after_rst4", {63'b0, done4}, 0);
        end
        go4(4'h9, 4'h9); wait4(-1); idle4();

        go4(4'hD, 4'h5); wait4(-1);
        go4(4'h8, 4'h8); wait4(-1);
        go4(4'h7, 4'h8); wait4(-1); idle4();

        go8(8'hFF, 8'hFF); wait8();
        for (int i = 0; i < 1000; i++) begin
            go8(8'($urandom), 8'($urandom));
            wait8();
        end
        @(negedge clk);
        chk("done_fall8", {63'b0, done8}, 0);

        repeat (2) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
